// File: rtl/lfsr_weight_init.sv
// -----------------------------------------------------------------------------
// lfsr_weight_init
//
// Turns 52-bit LFSR random words into a set of NUM_WEIGHTS signed initial
// unmixing weights for the fetal ECG ICA datapath. After a start request the
// block captures one random word at a time, cuts it into SPW = 52/SLICE_W
// two's-complement slices (slice 0 = LSBs), sign-extends each slice to OUT_W
// and streams the results to the weight-memory writer over valid/ready.
// A one-cycle done pulse follows acceptance of the last weight.
//
// Optional build macro:
//   LFSR_WEIGHT_CLAMP_EN - when defined, the most-negative slice code
//                          -2^(SLICE_W-1) is emitted as -2^(SLICE_W-1)+1 so
//                          the weight range is symmetric. Handshake, latency
//                          and ordering are unchanged.
//
// Ports:
//   clk        in   1      rising-edge clock
//   reset      in   1      synchronous, active-high; overrides everything
//   start      in   1      one-cycle request to generate a weight set
//   rnd_valid  in   1      rnd holds a fresh word this cycle
//   rnd        in   52     random word from the LFSR stage
//   w_valid    out  1      w_data / w_index valid
//   w_ready    in   1      downstream accepts the current weight
//   w_data     out  OUT_W  signed weight
//   w_index    out  IDX_W  weight number, 0..NUM_WEIGHTS-1
//   busy       out  1      high whenever the FSM is not idle
//   done       out  1      one-cycle pulse after the last weight is accepted
// -----------------------------------------------------------------------------
module lfsr_weight_init #(
    parameter  int NUM_WEIGHTS = 8,
    parameter  int SLICE_W     = 13,
    parameter  int OUT_W       = 16,
    localparam int IDX_W       = (NUM_WEIGHTS > 1) ? $clog2(NUM_WEIGHTS) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             rnd_valid,
    input  logic [51:0]      rnd,
    output logic             w_valid,
    input  logic             w_ready,
    output logic [OUT_W-1:0] w_data,
    output logic [IDX_W-1:0] w_index,
    output logic             busy,
    output logic             done
);

    localparam int SPW   = 52 / SLICE_W;
    localparam int SLC_W = (SPW > 1) ? $clog2(SPW) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_WEIGHTS - 1);
    localparam logic [SLC_W-1:0] LAST_SLICE = SLC_W'(SPW - 1);

    // Most-negative slice code and its symmetric replacement.
    localparam logic [SLICE_W-1:0] SLICE_MIN    = {1'b1, {(SLICE_W-1){1'b0}}};
    localparam logic [SLICE_W-1:0] SLICE_MIN_P1 = {1'b1, {(SLICE_W-2){1'b0}}, 1'b1};

    generate
        if (NUM_WEIGHTS < 1 || SLICE_W < 2 || (52 % SLICE_W) != 0 || OUT_W < SLICE_W) begin : g_bad_params
            $error("lfsr_weight_init: illegal parameter combination");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_RND,
        S_EMIT,
        S_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [51:0]      buf_q,   buf_d;
    logic [SLC_W-1:0] slice_q, slice_d;
    logic [IDX_W-1:0] wcnt_q,  wcnt_d;

    logic             accept;
    int               slice_off;
    logic [51:0]      shifted;
    logic [SLICE_W-1:0] slice_raw;
    logic [SLICE_W-1:0] slice_adj;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            buf_q   <= '0;
            slice_q <= '0;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            slice_q <= slice_d;
            wcnt_q  <= wcnt_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    // A weight leaves only when it is presented (EMIT) and the writer is ready.
    assign accept = (state_q == S_EMIT) && w_ready;

    // NOTE: every variable written here gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        slice_d = slice_q;
        wcnt_d  = wcnt_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_WAIT_RND;
                    wcnt_d  = '0;
                end
            end

            S_WAIT_RND: begin
                if (rnd_valid) begin
                    buf_d   = rnd;
                    slice_d = '0;
                    state_d = S_EMIT;
                end
            end

            S_EMIT: begin
                if (accept) begin
                    if (wcnt_q == LAST_IDX) begin
                        // Any unused slices of this word are simply dropped.
                        state_d = S_DONE;
                    end else if (slice_q == LAST_SLICE) begin
                        state_d = S_WAIT_RND;
                        wcnt_d  = wcnt_q + IDX_W'(1);
                    end else begin
                        slice_d = slice_q + SLC_W'(1);
                        wcnt_d  = wcnt_q + IDX_W'(1);
                    end
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Output logic
    // -------------------------------------------------------------------------
    always_comb begin
        slice_off = int'(slice_q) * SLICE_W;
        shifted   = buf_q >> slice_off;
        slice_raw = shifted[SLICE_W-1:0];

`ifdef LFSR_WEIGHT_CLAMP_EN
        slice_adj = (slice_raw == SLICE_MIN) ? SLICE_MIN_P1 : slice_raw;
`else
        slice_adj = slice_raw;
`endif

        w_valid = (state_q == S_EMIT);
        busy    = (state_q != S_IDLE);
        done    = (state_q == S_DONE);

        // Data and index read as zero whenever nothing is offered; while a
        // weight is offered they depend only on registers, so they hold
        // steady under backpressure.
        w_data  = w_valid ? OUT_W'($signed(slice_adj)) : '0;
        w_index = w_valid ? wcnt_q : '0;
    end

endmodule

// File: tb/tb_lfsr_weight_init.sv
module tb_lfsr_weight_init;

    localparam int NUM     = 8;
    localparam int SLICE_W = 13;
    localparam int OUT_W   = 16;
    localparam int SPW     = 52 / SLICE_W;
    localparam int IDX_W   = (NUM > 1) ? $clog2(NUM) : 1;
    localparam int NWORDS  = (NUM + SPW - 1) / SPW;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic             rnd_valid;
    logic [51:0]      rnd;
    logic             w_valid;
    logic             w_ready;
    logic [OUT_W-1:0] w_data;
    logic [IDX_W-1:0] w_index;
    logic             busy;
    logic             done;

    lfsr_weight_init #(
        .NUM_WEIGHTS (NUM),
        .SLICE_W     (SLICE_W),
        .OUT_W       (OUT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .rnd_valid (rnd_valid),
        .rnd       (rnd),
        .w_valid   (w_valid),
        .w_ready   (w_ready),
        .w_data    (w_data),
        .w_index   (w_index),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // ---------------------------------------------------------------- checking
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: weight k is slice (k mod SPW) of word (k div SPW),
    // interpreted as a two's-complement SLICE_W-bit number.
    function automatic logic [OUT_W-1:0] model_weight(input logic [51:0] word, input int s);
        longint raw;
        longint v;
        raw = longint'(word >> (s * SLICE_W)) & ((longint'(1) << SLICE_W) - 1);
        v   = (raw >= (longint'(1) << (SLICE_W - 1))) ? raw - (longint'(1) << SLICE_W) : raw;
`ifdef LFSR_WEIGHT_CLAMP_EN
        if (v == -(longint'(1) << (SLICE_W - 1))) v = v + 1;
`endif
        return OUT_W'(v);
    endfunction

    typedef struct {
        int               idx;
        logic [OUT_W-1:0] data;
    } exp_t;

    exp_t        exp_q[$];
    logic [51:0] words[NWORDS];

    task automatic push_all();
        exp_t e;
        for (int k = 0; k < NUM; k++) begin
            e.idx  = k;
            e.data = model_weight(words[k / SPW], k % SPW);
            exp_q.push_back(e);
        end
    endtask

    // Monitor: scoreboard pops on every accept, hold checks on every stall.
    int               done_cnt = 0;
    bit               stall_prev = 1'b0;
    logic [OUT_W-1:0] hold_data;
    logic [IDX_W-1:0] hold_idx;

    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("hold_valid", w_valid, 1);
                check("hold_data", w_data, hold_data);
                check("hold_index", w_index, hold_idx);
            end
            if (w_valid && w_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL sb_unexpected: got index %0d data %0h, none expected", w_index, w_data);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_index", w_index, e.idx);
                    check("sb_data", w_data, e.data);
                end
            end
            if (done) done_cnt++;
            stall_prev = w_valid && !w_ready;
            hold_data  = w_data;
            hold_idx   = w_index;
        end
    end

    // ---------------------------------------------------------------- stimulus
    int rdy_mode = 0;  // 0: w_ready held by test code, 1: random each cycle
    int n_acc    = 0;

    task automatic tick();
        bit acc;
        acc = w_valid && w_ready && !reset;
        @(posedge clk);
        if (acc) n_acc++;
        #1;
        if (rdy_mode == 1) w_ready = 1'($urandom_range(0, 1));
    endtask

    function automatic logic [51:0] rand52();
        return 52'({$urandom(), $urandom()});
    endfunction

    task automatic start_pulse();
        start     = 1'b1;
        rnd_valid = 1'b1;          // must not be captured from IDLE
        rnd       = rand52();
        tick();
        start     = 1'b0;
        rnd_valid = 1'b0;
        check("busy_after_start", busy, 1);
    endtask

    task automatic feed_word(input logic [51:0] word);
        check("wait_no_valid", w_valid, 0);
        rnd_valid = 1'b1;
        rnd       = word;
        tick();
        rnd_valid = 1'b0;
        rnd       = rand52();
        check("first_valid_latency", w_valid, 1);
    endtask

    // Runs until n_acc reaches target, with ignored rnd_valid/start noise.
    task automatic wait_acc(input int target, input bit hammer);
        int b = 0;
        while (n_acc < target && b < 300) begin
            rnd_valid = 1'($urandom_range(0, 1));
            rnd       = rand52();
            start     = hammer && ($urandom_range(0, 3) == 0);
            tick();
            b++;
        end
        rnd_valid = 1'b0;
        start     = 1'b0;
        check("acc_count", n_acc, target);
    endtask

    task automatic wait_done(input bit start_in_done);
        int b = 0;
        while (!done && b < 50) begin
            tick();
            b++;
        end
        check("done_seen", done, 1);
        check("done_no_valid", w_valid, 0);
        start = start_in_done;
        tick();
        start = 1'b0;
        check("idle_after_done", busy, 0);
        check("done_one_cycle", done, 0);
    endtask

    task automatic run_random_set(input bit hammer);
        int d0;
        int gaps;
        d0    = done_cnt;
        n_acc = 0;
        for (int j = 0; j < NWORDS; j++) words[j] = rand52();
        push_all();
        rdy_mode = 1;
        start_pulse();
        for (int j = 0; j < NWORDS; j++) begin
            if (j > 0) wait_acc(j * SPW, hammer);
            gaps = $urandom_range(0, 2);
            repeat (gaps) begin
                tick();
                check("gap_no_valid", w_valid, 0);
            end
            feed_word(words[j]);
        end
        wait_acc(NUM, hammer);
        wait_done(hammer);
        check("done_pulses", done_cnt - d0, 1);
        check("sb_drained", exp_q.size(), 0);
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [OUT_W-1:0] tab[4];
        int d0;

        reset = 1'b1; start = 1'b0; rnd_valid = 1'b0; rnd = '0; w_ready = 1'b0;
        tick();
        check("reset_outputs", {w_valid, w_data, w_index, busy, done}, 0);
        tick();
        reset = 1'b0;

        // Idle: noise on rnd_valid / w_ready must not wake the block.
        rdy_mode = 1;
        repeat (20) begin
            rnd_valid = 1'($urandom_range(0, 1));
            rnd       = rand52();
            tick();
            check("idle_outputs", {w_valid, w_data, w_index, busy, done}, 0);
        end
        rnd_valid = 1'b0;

        // Directed word, constant ready: one weight per cycle.
        tab[0] = 16'h0001; tab[1] = 16'hFFFF; tab[2] = 16'h0FFF;
`ifdef LFSR_WEIGHT_CLAMP_EN
        tab[3] = 16'hF001;
`else
        tab[3] = 16'hF000;
`endif
        words[0] = {13'h1000, 13'h0FFF, 13'h1FFF, 13'h0001};
        words[1] = rand52();
        push_all();
        d0 = done_cnt; n_acc = 0;
        rdy_mode = 0; w_ready = 1'b1;
        start_pulse();
        feed_word(words[0]);
        for (int i = 0; i < SPW; i++) begin
            check("dir_valid", w_valid, 1);
            check("dir_index", w_index, i);
            check("dir_data", w_data, tab[i]);
            tick();
        end
        feed_word(words[1]);
        for (int i = SPW; i < NUM; i++) begin
            check("dir_valid", w_valid, 1);
            check("dir_index", w_index, i);
            tick();
        end
        wait_done(0);
        check("done_pulses", done_cnt - d0, 1);
        check("sb_drained", exp_q.size(), 0);

        // Backpressure at index 1.
        words[0] = rand52();
        words[0][25:13] = 13'h1FFF;
        words[1] = rand52();
        push_all();
        d0 = done_cnt; n_acc = 0;
        rdy_mode = 0; w_ready = 1'b1;
        start_pulse();
        feed_word(words[0]);
        tick();
        w_ready = 1'b0;
        repeat (5) begin
            check("bp_valid", w_valid, 1);
            check("bp_index", w_index, 1);
            check("bp_data", w_data, 16'hFFFF);
            tick();
        end
        w_ready = 1'b1;
        rdy_mode = 1;
        wait_acc(SPW, 0);
        feed_word(words[1]);
        wait_acc(NUM, 0);
        wait_done(0);
        check("done_pulses", done_cnt - d0, 1);
        check("sb_drained", exp_q.size(), 0);

        // Reset in the middle of a set, at index 2.
        words[0] = rand52();
        words[1] = rand52();
        push_all();
        d0 = done_cnt; n_acc = 0;
        rdy_mode = 0; w_ready = 1'b1;
        start_pulse();
        feed_word(words[0]);
        tick();
        tick();
        check("rst_pre_index", w_index, 2);
        reset = 1'b1;
        exp_q.delete();
        tick();
        reset = 1'b0;
        check("rst_outputs", {w_valid, busy, done}, 0);
        tick();
        tick();
        check("rst_no_done", done_cnt - d0, 0);
        run_random_set(0);

        // Random sets with start hammered while busy and in the done cycle.
        repeat (5) run_random_set(1);

        check("sb_final_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
